// File: rtl/fib_lfsr_pkg.sv
// Shared definitions for the 5-bit Fibonacci LFSR (x^5 + x^3 + 1) generator and checker.
package fib_lfsr_pkg;

  localparam int unsigned LFSR_W = 5;
  localparam int unsigned TAP_HI = 4;
  localparam int unsigned TAP_LO = 2;

  typedef enum logic [1:0] {
    HUNT,
    VERIFY,
    LOCKED
  } chk_state_e;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], s[TAP_HI] ^ s[TAP_LO]};
  endfunction

endpackage

// File: rtl/fib_lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != '1)) begin
      count_q <= count_q + W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/fib_lfsr_checker.sv
// Self-synchronising checker for the x^5 + x^3 + 1 Fibonacci LFSR stream:
// hunts for a seed, verifies a run of predictions, then flywheels while locked.
module fib_lfsr_checker
  import fib_lfsr_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned LOSS_COUNT = 3,
  parameter int unsigned ERR_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LFSR_W-1:0] data_in,
  input  logic              data_valid,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_count
);

  localparam int unsigned RUN_MAX = (LOCK_COUNT > LOSS_COUNT) ? LOCK_COUNT : LOSS_COUNT;
  localparam int unsigned RUN_W   = (RUN_MAX < 2) ? 1 : $clog2(RUN_MAX + 1);

  chk_state_e        state_q, state_d;
  logic [LFSR_W-1:0] exp_q, exp_d;
  logic [RUN_W-1:0]  run_q, run_d;
  logic [RUN_W-1:0]  run_inc;
  logic              locked_q;
  logic              pulse_q, pulse_d;
  logic              err_inc;
  logic              match;

  assign run_inc = run_q + RUN_W'(1);
  assign match   = (data_in == exp_q);

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    run_d   = run_q;
    pulse_d = 1'b0;
    err_inc = 1'b0;
    if (data_valid) begin
      case (state_q)
        HUNT: begin
          if (data_in != '0) begin
            exp_d   = lfsr_next(data_in);
            run_d   = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (match) begin
            exp_d = lfsr_next(exp_q);
            if (run_inc == RUN_W'(LOCK_COUNT)) begin
              state_d = LOCKED;
              run_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end else if (data_in != '0) begin
            exp_d = lfsr_next(data_in);
            run_d = '0;
          end else begin
            state_d = HUNT;
            run_d   = '0;
          end
        end
        LOCKED: begin
          // Flywheel: prediction advances on every sample so phase survives bad words.
          exp_d = lfsr_next(exp_q);
          if (match) begin
            run_d = '0;
          end else begin
            pulse_d = 1'b1;
            err_inc = 1'b1;
            if (run_inc == RUN_W'(LOSS_COUNT)) begin
              state_d = HUNT;
              run_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end
        end
        default: begin
          state_d = HUNT;
          run_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= HUNT;
      exp_q    <= '0;
      run_q    <= '0;
      locked_q <= 1'b0;
      pulse_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      run_q    <= run_d;
      locked_q <= (state_d == LOCKED);
      pulse_q  <= pulse_d;
    end
  end

  sat_counter #(
    .W(ERR_W)
  ) u_err_cnt (
    .clk_i   (clk),
    .rst_i   (rst),
    .clr_i   (1'b0),
    .inc_i   (err_inc),
    .count_o (err_count)
  );

  assign locked    = locked_q;
  assign err_pulse = pulse_q;

endmodule

// File: tb/tb_fib_lfsr_checker.sv
// Directed bench for fib_lfsr_checker: vector table plus hand-written multi-cycle sequences.
module tb_fib_lfsr_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  data_in = '0;
  logic        data_valid = 1'b0;
  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic        locked_s, pulse_s;
  logic [1:0]  cnt_s;

  int unsigned pass_cnt  = 0;
  int unsigned total_cnt = 0;

  // Hand-computed maximal-length sequence starting from 00001.
  logic [4:0] seq [0:30] = '{
    5'b00001, 5'b00010, 5'b00100, 5'b01001, 5'b10010, 5'b00101, 5'b01011, 5'b10110,
    5'b01100, 5'b11001, 5'b10011, 5'b00111, 5'b01111, 5'b11111, 5'b11110, 5'b11100,
    5'b11000, 5'b10001, 5'b00011, 5'b00110, 5'b01101, 5'b11011, 5'b10111, 5'b01110,
    5'b11101, 5'b11010, 5'b10101, 5'b01010, 5'b10100, 5'b01000, 5'b10000
  };

  typedef struct {
    logic        v;
    logic [4:0]  d;
    logic        lk;
    logic        pl;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  fib_lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_W(16)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .locked(locked), .err_pulse(err_pulse), .err_count(err_count)
  );

  fib_lfsr_checker #(.LOCK_COUNT(4), .LOSS_COUNT(3), .ERR_W(2)) dut_sat (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .locked(locked_s), .err_pulse(pulse_s), .err_count(cnt_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step(input logic v, input logic [4:0] d);
    data_valid = v;
    data_in    = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic feed(input int start, input int n);
    for (int i = 0; i < n; i++) step(1'b1, seq[(start + i) % 31]);
  endtask

  function automatic vec_t mk(input logic v, input logic [4:0] d, input logic lk,
                              input logic pl, input logic [15:0] cnt);
    vec_t r;
    r.v = v; r.d = d; r.lk = lk; r.pl = pl; r.cnt = cnt;
    return r;
  endfunction

  initial begin
    // Clean lock, single error, loss, re-lock
    vecs.push_back(mk(1, 5'b00001, 0, 0, 0));
    vecs.push_back(mk(1, 5'b00010, 0, 0, 0));
    vecs.push_back(mk(0, 5'b11111, 0, 0, 0));
    vecs.push_back(mk(1, 5'b00100, 0, 0, 0));
    vecs.push_back(mk(1, 5'b01001, 0, 0, 0));
    vecs.push_back(mk(1, 5'b10010, 1, 0, 0));
    vecs.push_back(mk(1, 5'b00101, 1, 0, 0));
    vecs.push_back(mk(1, 5'b11111, 1, 1, 1));
    vecs.push_back(mk(0, 5'b00000, 1, 0, 1));
    vecs.push_back(mk(1, 5'b10110, 1, 0, 1));
    vecs.push_back(mk(1, 5'b01100, 1, 0, 1));
    vecs.push_back(mk(1, 5'b00000, 1, 1, 2));
    vecs.push_back(mk(1, 5'b00000, 1, 1, 3));
    vecs.push_back(mk(1, 5'b00000, 0, 1, 4));
    vecs.push_back(mk(1, 5'b00001, 0, 0, 4));
    vecs.push_back(mk(1, 5'b00010, 0, 0, 4));
    vecs.push_back(mk(1, 5'b00100, 0, 0, 4));
    vecs.push_back(mk(1, 5'b01001, 0, 0, 4));
    vecs.push_back(mk(1, 5'b10010, 1, 0, 4));

    do_reset();
    step(1'b0, 5'b00000);
    chk("reset_locked", {31'd0, locked}, 32'd0);
    chk("reset_pulse", {31'd0, err_pulse}, 32'd0);
    chk("reset_count", {16'd0, err_count}, 32'd0);
    chk("reset_count_sat", {30'd0, cnt_s}, 32'd0);

    foreach (vecs[i]) begin
      step(vecs[i].v, vecs[i].d);
      chk($sformatf("vec%0d_locked", i), {31'd0, locked}, {31'd0, vecs[i].lk});
      chk($sformatf("vec%0d_pulse", i), {31'd0, err_pulse}, {31'd0, vecs[i].pl});
      chk($sformatf("vec%0d_count", i), {16'd0, err_count}, {16'd0, vecs[i].cnt});
    end

    // Loss of lock from a fresh lock, then re-lock keeps count
    do_reset();
    feed(0, 5);
    chk("loss_locked_pre", {31'd0, locked}, 32'd1);
    step(1'b1, ~seq[5]);
    chk("loss1_locked", {31'd0, locked}, 32'd1);
    chk("loss1_pulse", {31'd0, err_pulse}, 32'd1);
    step(1'b1, ~seq[6]);
    chk("loss2_locked", {31'd0, locked}, 32'd1);
    chk("loss2_pulse", {31'd0, err_pulse}, 32'd1);
    step(1'b1, ~seq[7]);
    chk("loss3_locked", {31'd0, locked}, 32'd0);
    chk("loss3_pulse", {31'd0, err_pulse}, 32'd1);
    chk("loss3_count", {16'd0, err_count}, 32'd3);
    feed(10, 4);
    chk("relock_early", {31'd0, locked}, 32'd0);
    feed(14, 1);
    chk("relock_locked", {31'd0, locked}, 32'd1);
    chk("relock_count", {16'd0, err_count}, 32'd3);

    // Zero words in HUNT, then a clean stream with 0..3 cycle gaps
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 5'b00000);
    chk("zero_hunt_locked", {31'd0, locked}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      repeat (i % 4) step(1'b0, 5'b10101);
      step(1'b1, seq[20 + i]);
      chk($sformatf("gap%0d_pulse", i), {31'd0, err_pulse}, 32'd0);
      if (i == 3) chk("gap_not_yet_locked", {31'd0, locked}, 32'd0);
    end
    chk("gap_locked", {31'd0, locked}, 32'd1);
    chk("gap_count", {16'd0, err_count}, 32'd0);

    // Reset mid-operation while locked with two errors
    do_reset();
    feed(0, 5);
    step(1'b1, ~seq[5]);
    step(1'b1, seq[6]);
    step(1'b1, ~seq[7]);
    chk("midrst_pre_count", {16'd0, err_count}, 32'd2);
    chk("midrst_pre_locked", {31'd0, locked}, 32'd1);
    rst        = 1'b1;
    data_valid = 1'b1;
    data_in    = seq[8];
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_locked", {31'd0, locked}, 32'd0);
    chk("midrst_count", {16'd0, err_count}, 32'd0);
    feed(9, 4);
    chk("midrst_relock_early", {31'd0, locked}, 32'd0);
    feed(13, 1);
    chk("midrst_relock", {31'd0, locked}, 32'd1);

    // Saturation of a 2-bit counter with mismatches interleaved with matches
    do_reset();
    feed(0, 5);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, ~seq[5 + 2 * k]);
      chk($sformatf("sat%0d_pulse", k), {31'd0, pulse_s}, 32'd1);
      chk($sformatf("sat%0d_count", k), {30'd0, cnt_s}, (k < 3) ? k + 1 : 3);
      step(1'b1, seq[6 + 2 * k]);
    end
    chk("sat_final_count", {30'd0, cnt_s}, 32'd3);
    chk("sat_wide_count", {16'd0, err_count}, 32'd5);
    chk("sat_locked", {31'd0, locked_s}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fib_lfsr_checker.md
# fib_lfsr_checker

Receive-side checker for the 5-bit Fibonacci pseudo-random stream produced by `fib_random_design`, polynomial x^5 + x^3 + 1. It self-synchronises to the incoming words and then free-runs a local copy of the LFSR. Each received word is compared against the prediction. The block reports lock status, per-word mismatch pulses and a saturating error count, and sits downstream of the generator in the link/self-test path.

## Interface
- `LOCK_COUNT`, default 4: consecutive correct predictions needed to declare lock.
- `LOSS_COUNT`, default 3: consecutive mismatches while locked that drop lock.
- `ERR_W`, default 16: width of the error counter.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `data_in`, input, 5: received LFSR word.
- `data_valid`, input, 1: `data_in` is a new sample this cycle. Samples are consumed only when high.
- `locked`, output, 1: checker is in LOCKED state.
- `err_pulse`, output, 1: one-cycle pulse for a mismatch detected while LOCKED.
- `err_count`, output, `ERR_W`: saturating count of locked mismatches.

## Operation
- Step function: next(s) = {s[3:0], s[4]^s[2]}.
  - Maximal length is 31.
  - 5'b00000 is the lockup state and is never a legal seed.
- Registers:
  - `expected[4:0]`
  - `state`
  - `run_cnt`: counts up to max(`LOCK_COUNT`, `LOSS_COUNT`).
  - `err_count`
- States and transitions:
  - **HUNT**
    - On valid with `data_in` != 0: `expected` <= next(`data_in`), `run_cnt` <= 0, go to VERIFY.
    - On valid with `data_in` == 0: stay in HUNT.
  - **VERIFY**
    - On valid match: `run_cnt`++ and `expected` <= next(`expected`).
    - When `run_cnt` reaches `LOCK_COUNT`: go to LOCKED, `run_cnt` <= 0.
    - On valid mismatch: reseed from the current word. Nonzero word: `expected` <= next(`data_in`), `run_cnt` <= 0, stay in VERIFY. Zero word: go to HUNT.
    - No errors are counted in VERIFY.
  - **LOCKED** (flywheel)
    - Every valid sample advances: `expected` <= next(`expected`), regardless of match.
    - Match: `run_cnt` <= 0.
    - Mismatch: `err_pulse` fires, `err_count` += 1 (saturating at all-ones), `run_cnt`++.
    - When the mismatch run reaches `LOSS_COUNT`: go to HUNT, `run_cnt` <= 0.
- Idle handling: when `data_valid` = 0, all state, `expected` and `run_cnt` hold. Gaps never count as errors.
- `err_count` is cleared only by `rst`. It persists across loss and re-lock.

## Timing
- All outputs are registered.
- Reset values: `locked` = 0, `err_pulse` = 0, `err_count` = 0, state = HUNT, `expected` = 0, `run_cnt` = 0.
- Reset is synchronous and overrides everything. Asserting it mid-stream returns the block to HUNT on the next edge and clears the count.
- `err_pulse` is high in the cycle after the edge that samples the mismatching word, for exactly one cycle per bad word.
- Lock latency on a clean stream: `LOCK_COUNT`+1 valid samples (one seed plus `LOCK_COUNT` matches). `locked` rises on the edge that samples the last of them.
- Loss latency: `locked` falls on the edge that samples the `LOSS_COUNT`-th consecutive mismatch. That word still produces `err_pulse` and increments the count.
- Back-to-back valid samples every cycle are supported. So are arbitrary gaps.

## Structure
- Shared package `fib_lfsr_pkg`, used by both `fib_random_design` and this block:
  - the state enum (HUNT, VERIFY, LOCKED);
  - `LFSR_W` = 5;
  - the tap constants;
  - a function `lfsr_next(s)`.
- One sub-module is natural: `sat_counter` (parameterised width, inc and clear, saturating), used for `err_count`.
- Everything else lives in a single FSM module.

## Test plan
- **Clean lock:** reset, then feed valid each cycle 00001, 00010, 00100, 01001, 10010, 00101. Required: `locked` = 1 after the 5th word, `err_count` = 0, `err_pulse` never high.
- **Single error while locked:** after lock, replace the expected 01011 with 11111, then continue the correct sequence. Required: one `err_pulse`, `err_count` = 1, `locked` stays 1, and the next correct word matches (flywheel kept phase).
- **Loss of lock:** after lock, feed 3 consecutive wrong words. Required: 3 pulses, `err_count` = 3, `locked` = 0 after the 3rd. A subsequent clean stream re-locks after 5 words, and `err_count` stays at 3.
- **Zero and gaps:** in HUNT feed 00000 repeatedly. Required: stays unlocked. Then feed a clean sequence with `data_valid` gaps of 0–3 cycles. Required: locks, zero errors.
- **Reset mid-operation:** assert `rst` for one cycle while locked with `err_count` = 2. Required: next cycle `locked` = 0 and `err_count` = 0, and re-lock is required.
- **Saturation:** with `ERR_W` = 2, force 5 locked mismatches interleaved with matches. Required: `err_count` holds at 3 with no wrap, and `err_pulse` still fires each time.
